// File: rtl/moore_det_pkg.sv
// Shared constants and helpers for the Moore sequence detector.
package moore_det_pkg;

  localparam int unsigned PAT_W_MIN = 2;
  localparam int unsigned PAT_W_MAX = 8;
  localparam int unsigned CNT_W_MIN = 1;
  localparam int unsigned CNT_W_MAX = 16;

  // Bits needed to hold a prefix length in 0..pat_w.
  function automatic int unsigned len_w(input int unsigned pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage

// File: rtl/seq_prefix_match.sv
// Longest suffix of (history + x) that equals a prefix of the pattern.
module seq_prefix_match
  import moore_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  localparam int unsigned LW = len_w(PAT_W)
) (
  input  logic [PAT_W-1:0] pat,
  input  logic [PAT_W-2:0] hist,
  input  logic [LW-1:0]    hist_len,
  input  logic             x,
  output logic [LW-1:0]    match_len_c
);

  // seq[0] is the newest bit, so a k-bit candidate is seq[k-1:0] read MSB-first.
  logic [PAT_W-1:0] seq;
  logic [PAT_W-1:0] mask;

  assign seq = {hist, x};

  always_comb begin
    match_len_c = '0;
    mask        = '0;
    for (int unsigned k = 1; k <= PAT_W; k++) begin
      if (k <= 32'(hist_len) + 32'd1) begin
        mask = PAT_W'((32'd1 << k) - 32'd1);
        if ((seq & mask) == (pat >> (PAT_W - k))) begin
          match_len_c = LW'(k);
        end
      end
    end
  end

endmodule

// File: rtl/moore_seq_detector.sv
// Programmable serial pattern detector; state is the matched prefix length.
module moore_seq_detector
  import moore_det_pkg::*;
#(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             x,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  output logic             y1,
  output logic             y2,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  localparam int unsigned LW = len_w(PAT_W);
  localparam logic [LW-1:0] L_MATCH = LW'(PAT_W);
  localparam logic [LW-1:0] L_ARMED = LW'(PAT_W - 1);

  if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX) begin : g_bad_pat_w
    $error("moore_seq_detector: PAT_W out of range 2..8");
  end
  if (CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_bad_cnt_w
    $error("moore_seq_detector: CNT_W out of range 1..16");
  end

  logic [PAT_W-1:0] pat_q, pat_nxt;
  logic [PAT_W-2:0] hist_q, hist_nxt;
  logic [LW-1:0]    len_q, len_nxt;
  logic [LW-1:0]    eff_len;
  logic [LW-1:0]    match_len_c;
  logic [CNT_W-1:0] cnt_nxt;

  // Leaving MATCH without overlap restarts from an empty history.
  assign eff_len = (len_q == L_MATCH && !overlap) ? '0 : len_q;

  seq_prefix_match #(.PAT_W(PAT_W)) u_match (
    .pat         (pat_q),
    .hist        (hist_q),
    .hist_len    (eff_len),
    .x           (x),
    .match_len_c (match_len_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q     <= '1;
      hist_q    <= '0;
      len_q     <= '0;
      match_cnt <= '0;
      y1        <= 1'b0;
      y2        <= 1'b0;
      cnt_sat   <= 1'b0;
    end else begin
      pat_q     <= pat_nxt;
      hist_q    <= hist_nxt;
      len_q     <= len_nxt;
      match_cnt <= cnt_nxt;
      y1        <= (len_nxt == L_MATCH);
      y2        <= (len_nxt == L_ARMED);
      cnt_sat   <= &cnt_nxt;
    end
  end

  // Load takes priority over sampling; otherwise advance only when enabled.
  always_comb begin
    pat_nxt  = pat_q;
    hist_nxt = hist_q;
    len_nxt  = len_q;
    cnt_nxt  = match_cnt;
    if (load) begin
      pat_nxt  = pat_in;
      hist_nxt = '0;
      len_nxt  = '0;
      cnt_nxt  = '0;
    end else if (en) begin
      len_nxt  = match_len_c;
      hist_nxt = (PAT_W - 1)'({hist_q, x});
      if (match_len_c == L_MATCH && !(&match_cnt)) begin
        cnt_nxt = match_cnt + CNT_W'(1);
      end
    end
  end

endmodule
